// File: rtl/repairmb_lane_checker.sv
// RepairMB partner lane checker: classifies the sideband functional-group mask into
// continue / repeat / train-error outcomes. Optional WAIT timeout under REPAIRMB_TIMEOUT_EN.
module repairmb_lane_checker #(
  parameter int NUM_GROUPS     = 2,
  parameter int MIN_GROUPS     = 1,
  parameter int MAX_REPEAT     = 1,
  parameter int CNT_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_start_check,
  input  logic                  i_second_check,
  input  logic [NUM_GROUPS-1:0] i_functional_lanes,
  input  logic                  i_tx_d2c_en,
  output logic                  o_done_check,
  output logic                  o_go_to_repeat,
  output logic                  o_go_to_train_error,
  output logic                  o_continue,
  output logic [NUM_GROUPS-1:0] o_lane_mask,
  output logic [CNT_W-1:0]      o_repeat_count,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_HOLD        = 2'd1,
    S_WAIT_REPEAT = 2'd2,
    S_HOLD2       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_CONT = 2'd0,
    C_DEG  = 2'd1,
    C_ERR  = 2'd2
  } cls_e;

  localparam int POP_W = $clog2(NUM_GROUPS + 1);
  localparam logic [POP_W-1:0]      POP_ALL  = POP_W'(NUM_GROUPS);
  localparam logic [POP_W-1:0]      POP_MIN  = POP_W'(MIN_GROUPS);
  localparam logic [NUM_GROUPS-1:0] LSB_ONE  = NUM_GROUPS'(1);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_REPEAT);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  // Adding the lowest set bit ripples through a single contiguous run and clears it,
  // so any bit still shared with the original mask means a second run exists.
  function automatic cls_e classify(input logic [NUM_GROUPS-1:0] m);
    logic [POP_W-1:0]      pop;
    logic [NUM_GROUPS-1:0] low;
    logic                  contiguous;
    pop = '0;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      pop = pop + POP_W'(m[i]);
    end
    low        = m & (~m + LSB_ONE);
    contiguous = (((m + low) & m) == '0);
    if (pop == POP_ALL)                      return C_CONT;
    if ((pop == '0) || (pop < POP_MIN))      return C_ERR;
    if (!contiguous)                         return C_ERR;
    return C_DEG;
  endfunction

  state_e                  state_q, state_d;
  logic                    start_q;
  logic [NUM_GROUPS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    cont_q, cont_d;
  logic                    rep_q, rep_d;
  logic                    err_q, err_d;
  logic                    done_q;

  logic                    start_edge;
  logic                    eval_first;
  logic                    eval_second;
  logic                    tmo_clr;
  logic                    tmo_hit;
  cls_e                    cls;

  // A check request is the rising edge of i_start_check; i_second_check and the
  // lane mask are only meaningful in the cycle that edge (or a deferred evaluation) occurs.
  assign start_edge = i_start_check & ~start_q;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    cont_d      = 1'b0;
    rep_d       = 1'b0;
    err_d       = 1'b0;
    eval_first  = 1'b0;
    eval_second = 1'b0;
    tmo_clr     = 1'b0;
    cls         = classify(i_functional_lanes);

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          if (i_second_check) begin
            err_d = 1'b1;
          end else if (i_tx_d2c_en) begin
            state_d = S_HOLD;
            tmo_clr = 1'b1;
          end else begin
            eval_first = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!i_tx_d2c_en) begin
          eval_first = 1'b1;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_REPEAT: begin
        if (start_edge) begin
          if (i_second_check) begin
            if (i_tx_d2c_en) begin
              state_d = S_HOLD2;
              tmo_clr = 1'b1;
            end else begin
              eval_second = 1'b1;
            end
          end else begin
            // A fresh first check abandons the repeat flow.
            cnt_d = '0;
            if (i_tx_d2c_en) begin
              state_d = S_HOLD;
              tmo_clr = 1'b1;
            end else begin
              eval_first = 1'b1;
            end
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HOLD2: begin
        if (!i_tx_d2c_en) begin
          eval_second = 1'b1;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (eval_first) begin
      case (cls)
        C_CONT: begin
          cont_d  = 1'b1;
          state_d = S_IDLE;
        end
        C_DEG: begin
          rep_d   = 1'b1;
          mask_d  = i_functional_lanes;
          cnt_d   = '0;
          state_d = S_WAIT_REPEAT;
          tmo_clr = 1'b1;
        end
        default: begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end

    if (eval_second) begin
      if (i_functional_lanes == mask_q) begin
        cont_d  = 1'b1;
        state_d = S_IDLE;
      end else if ((cls == C_DEG) && (cnt_q < CNT_MAX)) begin
        rep_d   = 1'b1;
        mask_d  = i_functional_lanes;
        cnt_d   = cnt_q + CNT_ONE;
        state_d = S_WAIT_REPEAT;
        tmo_clr = 1'b1;
      end else begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      rep_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_start_check;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      rep_q   <= rep_d;
      err_q   <= err_d;
      done_q  <= cont_d | rep_d | err_d;
    end
  end

`ifdef REPAIRMB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q != S_IDLE) && (tmo_cnt_q == TO_LAST);

  always_comb begin
    tmo_cnt_d = '0;
    if (!tmo_clr && (state_d != S_IDLE)) begin
      tmo_cnt_d = tmo_cnt_q + TO_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic unused_tmo_clr;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_clr = tmo_clr;
`endif

  assign o_done_check        = done_q;
  assign o_continue          = cont_q;
  assign o_go_to_repeat      = rep_q;
  assign o_go_to_train_error = err_q;
  assign o_lane_mask         = mask_q;
  assign o_repeat_count      = cnt_q;
  assign o_dbg_state         = state_q;

endmodule
